// File: rtl/disp_pkg.sv
// Shared types and segment codes for the 7-segment scan display.
// Segment codes are active-low, bit order {g,f,e,d,c,b,a}.
package disp_pkg;

  typedef enum logic {
    LOAD = 1'b0,
    SHOW = 1'b1
  } state_t;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/disp_scan_if.sv
// Valid/ready result stream feeding the display stage.
interface disp_scan_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/disp_scan_hex_to_7seg.sv
// Combinational nibble to active-low 7-segment code decoder.
module hex_to_7seg
  import disp_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nibble)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/disp_scan.sv
// Captures NUM_VAL results, then scans them as hex digits on a
// common-anode 7-segment array until the next reset.
//
// state | meaning
// LOAD  | accepting results into the buffer, display blank
// SHOW  | buffer frozen, digits multiplexed every REFRESH_DIV cycles
module disp_scan
  import disp_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int NUM_VAL     = 4,
  parameter int NUM_DIG     = NUM_VAL * DATA_W / 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic               clk,
  input  logic               rst,
  disp_scan_if.slave         in_bus,
  output logic               done,
  output logic [NUM_DIG-1:0] an,
  output logic [6:0]         seg,
  output logic               dp
);

  localparam int PTR_W = (NUM_VAL > 1) ? $clog2(NUM_VAL) : 1;
  localparam int DIG_W = (NUM_DIG > 1) ? $clog2(NUM_DIG) : 1;
  localparam int CNT_W = $clog2(REFRESH_DIV + 1);

  state_t                   state_q, state_d;
  logic [PTR_W-1:0]         wr_ptr;
  logic [DATA_W-1:0]        val_buf [NUM_VAL];
  logic [DIG_W-1:0]         dig_idx;
  logic [CNT_W-1:0]         ref_cnt;
  logic                     xfer;
  logic                     last_xfer;
  logic                     ref_tc;
  logic [NUM_VAL*DATA_W-1:0] flat;
  logic [3:0]               nibble;
  logic [6:0]               seg_code;

  assign in_bus.in_ready = (state_q == LOAD) && !rst;
  assign xfer            = in_bus.in_valid && in_bus.in_ready;
  assign last_xfer       = xfer && (wr_ptr == PTR_W'(NUM_VAL - 1));
  assign ref_tc          = (ref_cnt == CNT_W'(REFRESH_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= LOAD;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LOAD:    if (last_xfer) state_d = SHOW;
      SHOW:    state_d = SHOW;
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      done   <= 1'b0;
      for (int i = 0; i < NUM_VAL; i++) val_buf[i] <= '0;
    end else if (xfer) begin
      val_buf[wr_ptr] <= in_bus.in_data;
      wr_ptr          <= wr_ptr + PTR_W'(1);
      if (last_xfer) done <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_cnt <= '0;
      dig_idx <= '0;
    end else if (state_q == SHOW) begin
      if (ref_tc) begin
        ref_cnt <= '0;
        dig_idx <= (dig_idx == DIG_W'(NUM_DIG - 1)) ? '0 : dig_idx + DIG_W'(1);
      end else begin
        ref_cnt <= ref_cnt + CNT_W'(1);
      end
    end
  end

  // Flattened buffer: digit n is nibble n, so buf[k] low nibble lands on digit 2k.
  always_comb begin
    flat = '0;
    for (int i = 0; i < NUM_VAL; i++) flat[i*DATA_W +: DATA_W] = val_buf[i];
  end

  assign nibble = flat[int'(dig_idx)*4 +: 4];

  hex_to_7seg u_hex (
    .nibble (nibble),
    .seg    (seg_code)
  );

  always_ff @(posedge clk) begin
    if (rst || (state_q != SHOW)) begin
      an  <= '1;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= ~(NUM_DIG'(1) << dig_idx);
      seg <= seg_code;
      // Point marks the start of each value except the rightmost one.
      dp  <= !(!dig_idx[0] && (dig_idx != '0));
    end
  end

endmodule

// File: tb/tb_disp_scan.sv
// Randomized self-checking bench for disp_scan against a time-based display model.
module tb_disp_scan;

  localparam int DATA_W  = 8;
  localparam int NUM_VAL = 4;
  localparam int NUM_DIG = 8;
  localparam int REFRESH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       done;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;

  disp_scan_if #(.DATA_W(DATA_W)) bus ();

  disp_scan #(
    .DATA_W(DATA_W), .NUM_VAL(NUM_VAL), .NUM_DIG(NUM_DIG), .REFRESH_DIV(REFRESH)
  ) dut (
    .clk(clk), .rst(rst), .in_bus(bus), .done(done), .an(an), .seg(seg), .dp(dp)
  );

  always #5 clk = ~clk;

  int chk = 0;
  int err = 0;

  logic [7:0] m_vals[$];
  bit         m_done;
  int         m_cyc;
  logic [6:0] hex_tab [16];

  // Model: count edges since done; digit = ((cyc-1)/REFRESH) mod NUM_DIG.
  function automatic void model_edge();
    if (rst) begin
      m_vals.delete();
      m_done = 1'b0;
      m_cyc  = 0;
    end else if (!m_done) begin
      if (bus.in_valid) begin
        m_vals.push_back(bus.in_data);
        if (m_vals.size() == NUM_VAL) begin
          m_done = 1'b1;
          m_cyc  = 0;
        end
      end
    end else begin
      m_cyc++;
    end
  endfunction

  function automatic bit blank();
    return !m_done || (m_cyc == 0);
  endfunction

  function automatic int cur_dig();
    return ((m_cyc - 1) / REFRESH) % NUM_DIG;
  endfunction

  function automatic logic [7:0] exp_an();
    if (blank()) return 8'hFF;
    return ~(8'd1 << cur_dig());
  endfunction

  function automatic logic [6:0] exp_seg();
    logic [7:0] v;
    int d;
    if (blank()) return 7'h7F;
    d = cur_dig();
    v = m_vals[d / 2] >> (4 * (d % 2));
    return hex_tab[v[3:0]];
  endfunction

  function automatic logic exp_dp();
    int d;
    if (blank()) return 1'b1;
    d = cur_dig();
    return ((d % 2 == 0) && (d != 0)) ? 1'b0 : 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [7:0] d);
    bus.in_valid = v;
    bus.in_data  = d;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'($urandom));
      #1;
      chk++;
      if (bus.in_ready !== 1'b0) begin
        err++;
        $display("FAIL reset_ready got=%b exp=0", bus.in_ready);
      end
      tick();
      chk++;
      if ({an, seg, dp, done} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
        err++;
        $display("FAIL reset_out got an=%h seg=%h dp=%b done=%b exp an=ff seg=7f dp=1 done=0",
                 an, seg, dp, done);
      end
    end
    rst = 1'b0;
    drive(1'b0, 8'h00);
    #1;
    chk++;
    if (bus.in_ready !== 1'b1) begin
      err++;
      $display("FAIL reset_release_ready got=%b exp=1", bus.in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_burst();
    logic [7:0] vals [4];
    vals = '{8'h12, 8'h34, 8'hAB, 8'hF0};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, vals[i]);
      #1;
      chk++;
      if (bus.in_ready !== 1'b1) begin
        err++;
        $display("FAIL burst_ready idx=%0d got=%b exp=1", i, bus.in_ready);
      end
      tick();
      chk++;
      if (done !== (i == 3)) begin
        err++;
        $display("FAIL burst_done idx=%0d got=%b exp=%b", i, done, (i == 3));
      end
    end
    drive(1'b0, 8'h00);
    #1;
    chk++;
    if (bus.in_ready !== 1'b0) begin
      err++;
      $display("FAIL burst_ready_after got=%b exp=0", bus.in_ready);
    end
    for (int c = 1; c <= 40; c++) begin
      tick();
      chk++;
      if ({an, seg, dp, done} !== {exp_an(), exp_seg(), exp_dp(), m_done}) begin
        err++;
        $display("FAIL burst_scan cyc=%0d got an=%h seg=%h dp=%b done=%b exp an=%h seg=%h dp=%b",
                 c, an, seg, dp, done, exp_an(), exp_seg(), exp_dp());
      end
      if (c == 1 || c == 33) begin
        chk++;
        if ({an, seg} !== {8'hFE, 7'h24}) begin
          err++;
          $display("FAIL burst_digit0 cyc=%0d got an=%h seg=%h exp an=fe seg=24", c, an, seg);
        end
      end
      if (c == 5) begin
        chk++;
        if ({an, seg, dp} !== {8'hFD, 7'h79, 1'b1}) begin
          err++;
          $display("FAIL burst_digit1 got an=%h seg=%h dp=%b exp an=fd seg=79 dp=1", an, seg, dp);
        end
      end
      if (c == 9) begin
        chk++;
        if ({an, seg, dp} !== {8'hFB, 7'h19, 1'b0}) begin
          err++;
          $display("FAIL burst_digit2 got an=%h seg=%h dp=%b exp an=fb seg=19 dp=0", an, seg, dp);
        end
      end
      if (c == 29) begin
        chk++;
        if ({an, seg} !== {8'h7F, 7'h0E}) begin
          err++;
          $display("FAIL burst_digit7 got an=%h seg=%h exp an=7f seg=0e", an, seg);
        end
      end
    end
  endtask

  task automatic test_gapped();
    rst = 1'b1;
    drive(1'b0, 8'h00);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      drive(k[0], 8'($urandom));
      #1;
      chk++;
      if (bus.in_ready !== !m_done) begin
        err++;
        $display("FAIL gap_ready k=%0d got=%b exp=%b", k, bus.in_ready, !m_done);
      end
      tick();
      chk++;
      if ({an, seg, dp, done} !== {exp_an(), exp_seg(), exp_dp(), m_done}) begin
        err++;
        $display("FAIL gap_load k=%0d got an=%h seg=%h dp=%b done=%b exp done=%b",
                 k, an, seg, dp, done, m_done);
      end
    end
    drive(1'b1, 8'h55);
    for (int c = 0; c < 40; c++) begin
      tick();
      chk++;
      if ({an, seg, dp, done} !== {exp_an(), exp_seg(), exp_dp(), m_done}) begin
        err++;
        $display("FAIL gap_scan cyc=%0d got an=%h seg=%h dp=%b done=%b exp an=%h seg=%h dp=%b",
                 c, an, seg, dp, done, exp_an(), exp_seg(), exp_dp());
      end
    end
    drive(1'b0, 8'h00);
  endtask

  task automatic test_mid_reset();
    logic [7:0] vals [4];
    logic [6:0] lit [8];
    vals = '{8'h00, 8'h09, 8'hCE, 8'hD7};
    lit  = '{7'h40, 7'h40, 7'h10, 7'h40, 7'h06, 7'h46, 7'h78, 7'h21};
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 8'($urandom));
      tick();
    end
    rst = 1'b1;
    drive(1'b1, 8'($urandom));
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, vals[i]);
      tick();
    end
    drive(1'b0, 8'h00);
    for (int c = 1; c <= 33; c++) begin
      tick();
      chk++;
      if ({an, seg, dp, done} !== {exp_an(), exp_seg(), exp_dp(), m_done}) begin
        err++;
        $display("FAIL midrst_scan cyc=%0d got an=%h seg=%h dp=%b done=%b exp an=%h seg=%h dp=%b",
                 c, an, seg, dp, done, exp_an(), exp_seg(), exp_dp());
      end
      if ((c - 1) % REFRESH == 0 && c < 33) begin
        chk++;
        if (seg !== lit[(c - 1) / REFRESH]) begin
          err++;
          $display("FAIL midrst_digit d=%0d got seg=%h exp seg=%h", (c - 1) / REFRESH, seg,
                   lit[(c - 1) / REFRESH]);
        end
      end
    end
  endtask

  task automatic test_show_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'($urandom));
      tick();
    end
    drive(1'b0, 8'h00);
    for (int c = 0; c < 200 && m_cyc < 1 + 5 * REFRESH; c++) tick();
    chk++;
    if (an !== 8'hDF) begin
      err++;
      $display("FAIL showrst_digit5 got an=%h exp an=df", an);
    end
    rst = 1'b1;
    tick();
    chk++;
    if ({an, seg, dp, done} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
      err++;
      $display("FAIL showrst_out got an=%h seg=%h dp=%b done=%b exp an=ff seg=7f dp=1 done=0",
               an, seg, dp, done);
    end
    rst = 1'b0;
    #1;
    chk++;
    if (bus.in_ready !== 1'b1) begin
      err++;
      $display("FAIL showrst_ready got=%b exp=1", bus.in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 79) == 0);
      drive(($urandom_range(0, 2) != 0), 8'($urandom));
      #1;
      chk++;
      if (bus.in_ready !== (!m_done && !rst)) begin
        err++;
        $display("FAIL rand_ready cyc=%0d got=%b exp=%b", c, bus.in_ready, (!m_done && !rst));
      end
      tick();
      chk++;
      if ({an, seg, dp, done} !== {exp_an(), exp_seg(), exp_dp(), m_done}) begin
        err++;
        $display("FAIL rand_out cyc=%0d got an=%h seg=%h dp=%b done=%b exp an=%h seg=%h dp=%b done=%b",
                 c, an, seg, dp, done, exp_an(), exp_seg(), exp_dp(), m_done);
      end
    end
    rst = 1'b0;
    drive(1'b0, 8'h00);
  endtask

  initial begin
    hex_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    m_done = 1'b0;
    m_cyc  = 0;
    rst    = 1'b1;
    drive(1'b0, 8'h00);
    @(negedge clk);
    test_reset();
    test_burst();
    test_gapped();
    test_mid_reset();
    test_show_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

endmodule

// File: doc/disp_scan.md
Name: disp_scan

Overview:
- Final display stage; consumes the pooled results streamed from the 2x2 stage.
- Its `rst` is driven by the sequencer's `rst_disp`, so the block is held in reset until the sequencer's last phase.
- Captures NUM_VAL results, then time-multiplexes them as hex digits on an active-low common-anode 7-segment array.
- Holds the display until reset.

Parameters:
- DATA_W, 8: width of each result.
- NUM_VAL, 4: number of results captured.
- NUM_DIG, 8: digits driven; fixed at NUM_VAL*DATA_W/4.
- REFRESH_DIV, 100000: clk cycles each digit stays lit (1 ms at 100 MHz; benches use 4).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream result valid.
- in_data  in  DATA_W  upstream result.
- in_ready  out  1  block accepts a result.
- done  out  1  all NUM_VAL results captured.
- an  out  NUM_DIG  digit enables, active-low; an[0] is the rightmost digit.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.

Behaviour:
- Reset (rst high at a clk edge), values after the edge:
  - state LOAD, wr_ptr 0, buffer cleared to 0, dig_idx 0, refresh count 0.
  - done 0, an all 1, seg 7'h7F, dp 1.
- in_ready is combinational: (state==LOAD) && !rst.
- LOAD state:
  - A transfer occurs on an edge where in_valid && in_ready.
  - On a transfer: buf[wr_ptr] <= in_data, then wr_ptr increments.
  - No transfer: no change. in_valid may drop at any time.
  - The transfer with wr_ptr==NUM_VAL-1 moves state to SHOW and registers done=1 on the same edge.
  - While in LOAD, outputs stay blank (an all 1, seg 7'h7F, dp 1).
- SHOW state:
  - in_ready stays 0, in_valid/in_data are ignored, done stays 1.
  - The refresh counter runs 0..REFRESH_DIV-1.
  - When the counter is at its terminal value, it returns to 0 and dig_idx <= (dig_idx+1) mod NUM_DIG.
  - dig_idx wraps from NUM_DIG-1 to 0 with no gap.
- Digit mapping: digit 2k shows buf[k][3:0]; digit 2k+1 shows buf[k][7:4].
- Outputs are registered, one-cycle latency from dig_idx:
  - an <= ~(1<<dig_idx).
  - seg <= hex code of the selected nibble.
  - dp <= 0 when dig_idx is even and nonzero (separates values), else 1.
  - The first digit-0 pattern appears one edge after done rises.
  - Each digit is then held exactly REFRESH_DIV cycles.
- Hex codes (seg, active-low): 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E.
- Reset mid-operation, in either state: full return to the reset values. Any partial load is discarded and the next transfer lands in buf[0].
- Reset together with in_valid: reset wins, nothing is captured.
- The block never leaves SHOW except via reset.

Decomposition:
- Package disp_pkg:
  - state enum {LOAD, SHOW}.
  - The 16 seg code constants.
  - SEG_BLANK = 7'h7F.
- Sub-module hex_to_7seg: combinational, 4-bit nibble -> 7-bit active-low code.
- The FSM, buffer, refresh counter and output registers stay in disp_scan.

Test Plan (REFRESH_DIV=4):
- Reset: rst=1 for 3 edges with in_valid=1 -> an=8'hFF, seg=7'h7F, dp=1, done=0, in_ready=0, nothing captured.
- Burst load: 8'h12, 34, AB, F0 on 4 consecutive edges -> in_ready=1 for all 4; done=1 after the 4th edge; in_ready=0 thereafter.
- Scan order:
  - One edge after done: an=8'hFE, seg=7'h24 ('2').
  - After 4 more: an=8'hFD, seg=7'h79 ('1'), dp=1.
  - Next: an=8'hFB, seg=7'h19 ('4'), dp=0.
  - Digit 7: an=8'h7F, seg=7'h0E ('F').
  - After 32 cycles: back to an=8'hFE, seg=7'h24.
- Gapped input: in_valid toggles every other cycle, 4 values -> exactly 4 captures in order, done after the 4th accepted value; an extra valid with data 8'h55 after done changes no display.
- Mid-load reset: 2 values accepted, rst for 1 edge, then 4 new values 8'h00, 8'h09, 8'hCE, 8'hD7 -> digits show 0,0,9,0,E,C,7,d from digit 0 upward.
- Reset during SHOW: rst pulse at digit 5 -> next edge an=8'hFF, done=0, in_ready=1 after rst falls.
